rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 134 +++++++++++++
 tb/tb_rom_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Two-port arbiter sharing one combinational ROM: IDLE grants a requester, READ drives the ROM.
// Define ROM_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (port 0 wins).
module rom_arbiter #(
  parameter int A_BITS  = 8,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic [A_BITS-1:0]  addr0,
  output logic               gnt0,
  output logic               rvalid0,
  output logic [D_WIDTH-1:0] rdata0,
  input  logic               req1,
  input  logic [A_BITS-1:0]  addr1,
  output logic               gnt1,
  output logic               rvalid1,
  output logic [D_WIDTH-1:0] rdata1,
  output logic [A_BITS-1:0]  rom_a,
  input  logic [D_WIDTH-1:0] rom_d,
  output logic               rom_en,
  output logic               rom_ce,
  output logic               busy
);

  typedef enum logic {IDLE, READ} state_t;

  state_t               state_q, state_d;
  logic                 win_q, win_d;
  logic [A_BITS-1:0]    rom_a_q, rom_a_d;
  logic                 rom_en_q, rom_en_d;
  logic                 gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                 rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [D_WIDTH-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                 pick1;

`ifdef ROM_ARB_RR_EN
  // prio_q names the port that wins the next contention; it moves only on a grant
  logic prio_q, prio_d;
  assign pick1 = req1 && (!req0 || prio_q);
`else
  assign pick1 = req1 && !req0;
`endif

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    rom_a_d   = rom_a_q;
    rom_en_d  = rom_en_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
`ifdef ROM_ARB_RR_EN
    prio_d    = prio_q;
`endif
    case (state_q)
      IDLE: begin
        rom_en_d = 1'b0;
        rom_a_d  = '0;
        if (req0 || req1) begin
          state_d  = READ;
          win_d    = pick1;
          rom_a_d  = pick1 ? addr1 : addr0;
          rom_en_d = 1'b1;
          gnt0_d   = !pick1;
          gnt1_d   = pick1;
`ifdef ROM_ARB_RR_EN
          prio_d   = !pick1;
`endif
        end
      end
      READ: begin
        state_d  = IDLE;
        rom_en_d = 1'b0;
        rom_a_d  = '0;
        if (win_q) begin
          rdata1_d  = rom_d;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = rom_d;
          rvalid0_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      win_q     <= 1'b0;
      rom_a_q   <= '0;
      rom_en_q  <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
`ifdef ROM_ARB_RR_EN
      prio_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      rom_a_q   <= rom_a_d;
      rom_en_q  <= rom_en_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
`ifdef ROM_ARB_RR_EN
      prio_q    <= prio_d;
`endif
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign rom_a   = rom_a_q;
  assign rom_en  = rom_en_q;
  assign rom_ce  = rom_en_q;
  assign busy    = (state_q == READ);

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: cycle table for single accesses plus contention and mid-access reset sequences.
// Expectations for contention follow ROM_ARB_RR_EN when it is defined.
module tb_rom_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] addr0 = 8'h00, addr1 = 8'h00;
  logic       gnt0, gnt1, rvalid0, rvalid1, rom_en, rom_ce, busy;
  logic [7:0] rdata0, rdata1, rom_a, rom_d;
  logic [7:0] mem [256];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rom_d = mem[rom_a];

  rom_arbiter #(.A_BITS(8), .D_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .rom_a(rom_a), .rom_d(rom_d), .rom_en(rom_en), .rom_ce(rom_ce), .busy(busy)
  );

  typedef struct {
    logic       r0;
    logic [7:0] a0;
    logic       r1;
    logic [7:0] a1;
    logic [30:0] exp;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [30:0] mk(input logic g0, input logic g1, input logic v0, input logic v1,
                                     input logic act, input logic [7:0] a, input logic [7:0] d0,
                                     input logic [7:0] d1);
    return {g0, g1, v0, v1, act, act, act, a, d0, d1};
  endfunction

  function automatic logic [30:0] out_bus();
    return {gnt0, gnt1, rvalid0, rvalid1, rom_ce, rom_en, busy, rom_a, rdata0, rdata1};
  endfunction

  task automatic applyStimulus(input logic r0, input logic [7:0] a0, input logic r1, input logic [7:0] a1);
    @(negedge clk);
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [30:0] act, input logic [30:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // gnt and rvalid must be one-hot-or-zero on every cycle
  always @(negedge clk) begin
    checks++;
    if ((gnt0 && gnt1) || (rvalid0 && rvalid1)) begin
      failures++;
      $display("[TB] FAIL exclusive: gnt=%b%b rvalid=%b%b expected no overlap", gnt0, gnt1, rvalid0, rvalid1);
    end
  end

  initial begin
    logic exp1;
    logic [7:0] exp_d;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    mem[8'h10] = 8'hA5; mem[8'h20] = 8'h77; mem[8'h30] = 8'h88;
    mem[8'h40] = 8'h5A; mem[8'h50] = 8'h3C;

    vecs[0]  = '{1'b0, 8'h00, 1'b0, 8'h00, mk(0,0,0,0,0,8'h00,8'h00,8'h00)};
    vecs[1]  = '{1'b1, 8'h10, 1'b0, 8'h00, mk(1,0,0,0,1,8'h10,8'h00,8'h00)};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 8'h00, mk(0,0,1,0,0,8'h00,8'hA5,8'h00)};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, mk(0,0,0,0,0,8'h00,8'hA5,8'h00)};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 8'h20, mk(0,1,0,0,1,8'h20,8'hA5,8'h00)};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 8'h30, mk(0,0,0,1,0,8'h00,8'hA5,8'h77)};
    vecs[6]  = '{1'b1, 8'h40, 1'b0, 8'h30, mk(1,0,0,0,1,8'h40,8'hA5,8'h77)};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 8'h50, mk(0,0,1,0,0,8'h00,8'h5A,8'h77)};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 8'h50, mk(0,1,0,0,1,8'h50,8'h5A,8'h77)};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, mk(0,0,0,1,0,8'h00,8'h5A,8'h3C)};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 8'h00, mk(0,0,0,0,0,8'h00,8'h5A,8'h3C)};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", out_bus(), '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].r0, vecs[i].a0, vecs[i].r1, vecs[i].a1);
      checkOutput($sformatf("vec%0d", i), out_bus(), vecs[i].exp);
    end

    // reset asserted in the middle of a READ cycle
    applyStimulus(1'b1, 8'h10, 1'b0, 8'h00);
    checkOutput("pre_reset_read", out_bus(), mk(1,0,0,0,1,8'h10,8'h5A,8'h3C));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_immediate", out_bus(), '0);
    req0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("after_reset_1", out_bus(), '0);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("after_reset_2", out_bus(), '0);

    // both requesters held high: port 0 wins first after reset
    for (int k = 0; k < 4; k++) begin
`ifdef ROM_ARB_RR_EN
      exp1 = (k % 2) == 1;
`else
      exp1 = 1'b0;
`endif
      exp_d = exp1 ? 8'h77 : 8'hA5;
      applyStimulus(1'b1, 8'h10, 1'b1, 8'h20);
      checkOutput($sformatf("contend_gnt%0d", k), {30'd0, gnt0, gnt1} , {30'd0, !exp1, exp1});
      applyStimulus(1'b1, 8'h10, 1'b1, 8'h20);
      checkOutput($sformatf("contend_rv%0d", k), {21'd0, rvalid0, rvalid1, exp1 ? rdata1 : rdata0},
                  {21'd0, !exp1, exp1, exp_d});
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
